// File: rtl/sme_feeder.sv
// Host-side feeder for the string-matching engine: buffers one string and one
// pattern, streams them over the serial character interface, and reports the result.
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       reuse_str,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       res_error
);

  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int IW  = (SLW > PLW) ? SLW : PLW;
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_SEND_STR, S_SEND_PAT, S_WAIT, S_REPORT} state_t;

  state_t           r_state, w_state_nx;
  logic [7:0]       r_str_mem [STR_MAX];
  logic [7:0]       r_pat_mem [PAT_MAX];
  logic [SLW-1:0]   r_str_len, w_str_wptr;
  logic [PLW-1:0]   r_pat_len, w_pat_wptr;
  logic             r_str_fresh, r_pat_fresh;
  logic             r_str_sent, w_str_sent;
  logic [IW-1:0]    r_idx, w_idx;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [7:0]       r_chardata, w_chardata;
  logic             r_isstring, w_isstring, r_ispattern, w_ispattern;
  logic             r_done, w_done;
  logic             r_res_match, w_res_match, r_res_timeout, w_res_timeout;
  logic             r_res_error, w_res_error;
  logic [4:0]       r_res_index, w_res_index;
  logic             w_wr_ok, w_str_we, w_pat_we, w_use_reuse;

  // Loader writes only land in IDLE, and a same-cycle start takes precedence.
  assign w_wr_ok    = (r_state == S_IDLE) && wr_en && !start;
  assign w_str_wptr = r_str_fresh ? '0 : r_str_len;
  assign w_pat_wptr = r_pat_fresh ? '0 : r_pat_len;
  assign w_str_we   = w_wr_ok && !wr_sel && (w_str_wptr < SLW'(STR_MAX));
  assign w_pat_we   = w_wr_ok &&  wr_sel && (w_pat_wptr < PLW'(PAT_MAX));
  assign w_use_reuse = reuse_str && r_str_sent;

  // NOTE: character buffers carry no reset; the lengths alone define valid contents.
  always_ff @(posedge clk) begin
    if (w_str_we) r_str_mem[w_str_wptr[SAW-1:0]] <= wr_data;
    if (w_pat_we) r_pat_mem[w_pat_wptr[PAW-1:0]] <= wr_data;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nx    = r_state;
    w_idx         = r_idx;
    w_cnt         = r_cnt;
    w_str_sent    = r_str_sent;
    w_chardata    = 8'h00;
    w_isstring    = 1'b0;
    w_ispattern   = 1'b0;
    w_done        = 1'b0;
    w_res_match   = r_res_match;
    w_res_index   = r_res_index;
    w_res_timeout = r_res_timeout;
    w_res_error   = r_res_error;
    case (r_state)
      S_IDLE: if (start) begin
        if (r_pat_len == '0 || (!w_use_reuse && r_str_len == '0)) begin
          w_state_nx  = S_REPORT;
          w_done      = 1'b1;
          w_res_error = 1'b1;
        end else if (w_use_reuse) begin
          w_state_nx  = S_SEND_PAT;
          w_ispattern = 1'b1;
          w_chardata  = r_pat_mem[0];
          w_idx       = IW'(1);
        end else begin
          w_state_nx  = S_SEND_STR;
          w_isstring  = 1'b1;
          w_chardata  = r_str_mem[0];
          w_idx       = IW'(1);
          w_str_sent  = 1'b1;
        end
      end
      S_SEND_STR: begin
        if (r_idx == IW'(r_str_len)) begin
          w_state_nx  = S_SEND_PAT;
          w_ispattern = 1'b1;
          w_chardata  = r_pat_mem[0];
          w_idx       = IW'(1);
        end else begin
          w_isstring  = 1'b1;
          w_chardata  = r_str_mem[r_idx[SAW-1:0]];
          w_idx       = r_idx + IW'(1);
        end
      end
      S_SEND_PAT: begin
        if (r_idx == IW'(r_pat_len)) begin
          w_state_nx  = S_WAIT;
          w_cnt       = '0;
        end else begin
          w_ispattern = 1'b1;
          w_chardata  = r_pat_mem[r_idx[PAW-1:0]];
          w_idx       = r_idx + IW'(1);
        end
      end
      S_WAIT: begin
        if (valid) begin
          w_state_nx    = S_REPORT;
          w_done        = 1'b1;
          w_res_match   = match;
          w_res_index   = match_index;
          w_res_timeout = 1'b0;
          w_res_error   = 1'b0;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_nx    = S_REPORT;
          w_done        = 1'b1;
          w_res_match   = 1'b0;
          w_res_index   = 5'd0;
          w_res_timeout = 1'b1;
          w_res_error   = 1'b0;
        end else begin
          w_cnt         = r_cnt + CW'(1);
        end
      end
      S_REPORT: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_str_len     <= '0;
      r_pat_len     <= '0;
      r_str_fresh   <= 1'b0;
      r_pat_fresh   <= 1'b0;
      r_str_sent    <= 1'b0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_chardata    <= 8'h00;
      r_isstring    <= 1'b0;
      r_ispattern   <= 1'b0;
      r_done        <= 1'b0;
      r_res_match   <= 1'b0;
      r_res_index   <= 5'd0;
      r_res_timeout <= 1'b0;
      r_res_error   <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_str_sent    <= w_str_sent;
      r_idx         <= w_idx;
      r_cnt         <= w_cnt;
      r_chardata    <= w_chardata;
      r_isstring    <= w_isstring;
      r_ispattern   <= w_ispattern;
      r_done        <= w_done;
      r_res_match   <= w_res_match;
      r_res_index   <= w_res_index;
      r_res_timeout <= w_res_timeout;
      r_res_error   <= w_res_error;
      if (w_wr_ok && !wr_sel) r_str_fresh <= 1'b0;
      if (w_wr_ok &&  wr_sel) r_pat_fresh <= 1'b0;
      if (w_str_we) r_str_len <= w_str_wptr + SLW'(1);
      if (w_pat_we) r_pat_len <= w_pat_wptr + PLW'(1);
      // A completed job makes the next write to either buffer start over at index 0.
      if (r_state == S_REPORT) begin
        r_str_fresh <= 1'b1;
        r_pat_fresh <= 1'b1;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign chardata    = r_chardata;
  assign isstring    = r_isstring;
  assign ispattern   = r_ispattern;
  assign done        = r_done;
  assign res_match   = r_res_match;
  assign res_index   = r_res_index;
  assign res_timeout = r_res_timeout;
  assign res_error   = r_res_error;

endmodule

// File: tb/tb_sme_feeder.sv
// Self-checking bench for sme_feeder: directed and random jobs against a queue-based
// model of the buffers, the expected character stream and the reported results.
module tb_sme_feeder;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0, reset = 1'b0;
  logic       wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, reuse_str = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       valid = 1'b0, match = 1'b0;
  logic [4:0] match_index = 5'd0;
  logic       busy, isstring, ispattern, done, res_match, res_timeout, res_error;
  logic [7:0] chardata;
  logic [4:0] res_index;

  sme_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .start(start), .reuse_str(reuse_str), .busy(busy), .chardata(chardata),
    .isstring(isstring), .ispattern(ispattern), .valid(valid), .match(match),
    .match_index(match_index), .done(done), .res_match(res_match),
    .res_index(res_index), .res_timeout(res_timeout), .res_error(res_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte unsigned m_str[$];
  byte unsigned m_pat[$];
  bit           m_str_fresh = 0, m_pat_fresh = 0, m_str_sent = 0;
  bit           m_res_error = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_str.delete();
    m_pat.delete();
    m_str_fresh = 0;
    m_pat_fresh = 0;
    m_str_sent  = 0;
    m_res_error = 0;
  endtask

  task automatic wr(input bit sel, input byte unsigned d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (!sel) begin
      if (m_str_fresh) begin m_str.delete(); m_str_fresh = 0; end
      if (m_str.size() < STR_MAX) m_str.push_back(d);
    end else begin
      if (m_pat_fresh) begin m_pat.delete(); m_pat_fresh = 0; end
      if (m_pat.size() < PAT_MAX) m_pat.push_back(d);
    end
  endtask

  task automatic wr_text(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) wr(sel, s[i]);
  endtask

  // reply < 0 means the engine never answers.
  task automatic run_job(input bit reuse, input int reply, input logic m, input logic [4:0] idx,
                         input bit spur, input bit wr_too, input string tag);
    logic [9:0] exp_q[$];
    logic [9:0] exp_now;
    bit         use_reuse, err;
    int         n, lat, c, reply_c;
    use_reuse = reuse && m_str_sent;
    err = (m_pat.size() == 0) || (!use_reuse && m_str.size() == 0);
    if (!err) begin
      if (!use_reuse) begin
        foreach (m_str[i]) exp_q.push_back({2'b10, m_str[i]});
        m_str_sent = 1;
      end
      foreach (m_pat[i]) exp_q.push_back({2'b01, m_pat[i]});
    end
    n       = exp_q.size();
    reply_c = n + 1 + reply;
    if (err)            lat = 1;
    else if (reply < 0) lat = n + 1 + TIMEOUT;
    else                lat = n + 2 + reply;

    start = 1'b1; reuse_str = reuse;
    if (wr_too) begin wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'h5A; end
    @(negedge clk);
    start = 1'b0; reuse_str = 1'b0; wr_en = 1'b0;
    c = 1;
    while (done !== 1'b1 && c < n + TIMEOUT + 8) begin
      exp_now = (c - 1 < n) ? exp_q[c-1] : 10'h000;
      check($sformatf("%s stream c%0d", tag, c), {isstring, ispattern, chardata}, exp_now);
      check($sformatf("%s busy c%0d", tag, c), busy, 1'b1);
      if (spur && c == 1) begin
        valid = 1'b1; match = ~m; match_index = ~idx;
      end else if (!err && reply >= 0 && c == reply_c) begin
        valid = 1'b1; match = m; match_index = idx;
      end else begin
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
      end
      @(negedge clk);
      c++;
    end
    valid = 1'b0;
    check({tag, " latency"}, c, lat);
    check({tag, " done"}, done, 1'b1);
    check({tag, " quiet at done"}, {isstring, ispattern, chardata}, 10'h000);
    if (err) begin
      m_res_error = 1;
    end else begin
      m_res_error = 0;
      check({tag, " res_match"}, res_match, (reply < 0) ? 1'b0 : m);
      check({tag, " res_index"}, res_index, (reply < 0) ? 5'd0 : idx);
      check({tag, " res_timeout"}, res_timeout, (reply < 0) ? 1'b1 : 1'b0);
    end
    check({tag, " res_error"}, res_error, m_res_error);
    m_str_fresh = 1;
    m_pat_fresh = 1;
    @(negedge clk);
    check({tag, " done one cycle"}, done, 1'b0);
    check({tag, " idle busy"}, busy, 1'b0);
  endtask

  initial begin
    int s_len, p_len, sl;
    #1;
    check("reset outs", {busy, isstring, ispattern, chardata, done}, 12'h000);
    check("reset results", {res_match, res_index, res_timeout, res_error}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Full job, then a pattern-only job, then an unanswered one.
    wr_text(0, "abcde");
    wr_text(1, "cd");
    run_job(0, 3, 1'b1, 5'd2, 0, 0, "abcde");
    wr_text(1, "e$");
    run_job(1, 0, 1'b1, 5'd4, 0, 0, "reuse");
    run_job(1, -1, 1'b1, 5'd9, 0, 0, "timeout");

    // Write colliding with start is dropped; early valid is ignored.
    run_job(0, 4, 1'b0, 5'd17, 1, 1, "collide");

    for (int j = 0; j < 6; j++) begin
      if (j == 0 || $urandom_range(0, 3) != 0) begin
        s_len = $urandom_range(1, STR_MAX + 4);
        for (int i = 0; i < s_len; i++) wr(0, 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 3) != 0) begin
        p_len = $urandom_range(1, PAT_MAX + 2);
        for (int i = 0; i < p_len; i++) wr(1, 8'($urandom_range(0, 255)));
      end
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, 10), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, $sformatf("rand%0d", j));
    end

    // Reset during the third pattern character.
    wr_text(1, "wxyz");
    sl = m_str.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < sl + 3; c++) @(negedge clk);
    check("pre-reset pat char", {isstring, ispattern, chardata}, {2'b01, m_pat[2]});
    #2 reset = 1'b0;
    #1;
    check("midreset quals", {isstring, ispattern, chardata}, 10'h000);
    check("midreset busy/done", {busy, done}, 2'b00);
    check("midreset results", {res_match, res_index, res_timeout, res_error}, 8'h00);
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no done in reset", done, 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("post-reset done", {busy, done}, 2'b00);
    wr_text(0, "hello");
    wr_text(1, "lo");
    run_job(1, 2, 1'b1, 5'd3, 0, 0, "resend");

    // Saturated string with no pattern, then the same string with a pattern.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 40; i++) wr(0, 8'($urandom_range(0, 255)));
    run_job(0, 0, 1'b1, 5'd1, 0, 0, "nopat");
    wr_text(1, "q7");
    run_job(0, 1, 1'b1, 5'd31, 0, 0, "sat32");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
